// File: rtl/transmitter.sv
// transmitter: UART-style 8N1 serial transmitter (8E1 with TX_PARITY_EN); ports sclk, rst, write, char[7:0], div[15:0] in; ready, tx, busy out
module transmitter (
  input  logic        sclk,
  input  logic        rst,
  input  logic        write,
  input  logic [7:0]  char,
  input  logic [15:0] div,
  output logic        ready,
  output logic        tx,
  output logic        busy
);
`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [7:0] hold_q, hold_d, shift_q, shift_d;
  logic full_q, full_d, ready_q, tx_q, tx_d, busy_q;
  logic [2:0] bit_q, bit_d;
  logic [15:0] div_q, div_d, cnt_q, cnt_d;
  logic [3:0] tck_q, tck_d;
  logic tick, bit_end, load, accept;
`ifdef TX_PARITY_EN
  logic par_q, par_d;
`endif
  always_comb begin
    tick = state_q != IDLE && cnt_q == div_q - 16'd1;
    bit_end = tick && tck_q == 4'd15;
    load = full_q && (state_q == IDLE || (state_q == STOP && bit_end));
    accept = write && ready_q;
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    div_d = div_q;
    cnt_d = (tick || state_q == IDLE) ? 16'd0 : cnt_q + 16'd1;
    tck_d = tick ? tck_q + 4'd1 : tck_q;
    hold_d = accept ? char : hold_q;
    full_d = accept | (full_q & ~load);
    if (bit_end)
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          bit_d = bit_q + 3'd1;
`ifdef TX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
`ifdef TX_PARITY_EN
        PARITY: state_d = STOP;
`endif
        STOP: state_d = IDLE;
        default: ;
      endcase
    if (load) begin
      state_d = START;
      shift_d = hold_q;
      bit_d = 3'd0;
      div_d = (div == 16'd0) ? 16'd1 : div;
      cnt_d = 16'd0;
      tck_d = 4'd0;
    end
`ifdef TX_PARITY_EN
    par_d = load ? ^hold_q : par_q;
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      shift_q <= '0;
      full_q <= 1'b0;
      ready_q <= 1'b1;
      bit_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      tck_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      shift_q <= shift_d;
      full_q <= full_d;
      ready_q <= ~full_d;
      bit_q <= bit_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      tck_q <= tck_d;
      tx_q <= tx_d;
      busy_q <= state_d != IDLE;
    end
  end
`ifdef TX_PARITY_EN
  always_ff @(posedge sclk) par_q <= rst ? 1'b0 : par_d;
`endif
  assign ready = ready_q;
  assign tx = tx_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: directed self-checking bench for transmitter
module tb_transmitter;
  logic sclk = 1'b0, rst = 1'b1, write = 1'b0;
  logic [7:0] char_i = 8'h00;
  logic [15:0] div = 16'd1;
  logic ready, tx, busy;
  int total = 0, bad = 0;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  always #5 sclk = ~sclk;
  transmitter dut (.sclk(sclk), .rst(rst), .write(write), .char(char_i), .div(div),
                   .ready(ready), .tx(tx), .busy(busy));
  function automatic logic [10:0] fr(input logic [7:0] b, input logic p);
    return NB == 11 ? {1'b1, p, b, 1'b0} : {2'b01, b, 1'b0};
  endfunction
  task automatic step;
    @(posedge sclk);
    #1;
  endtask
  task automatic send_idle(input string nm, input logic [7:0] b);
    char_i = b;
    write = 1'b1;
    step;
    total++;
    if ({ready, busy} !== 2'b00) begin
      bad++;
      $display("FAIL %s n+1 {ready,busy}=%b want 00", nm, {ready, busy});
    end
    write = 1'b0;
    char_i = 8'hEE;
    step;
    total++;
    if ({tx, ready, busy} !== 3'b011) begin
      bad++;
      $display("FAIL %s n+2 {tx,ready,busy}=%b want 011", nm, {tx, ready, busy});
    end
  endtask
  task automatic check_frame(input string nm, input logic [10:0] bits, input int d,
                             input int w1, input logic [7:0] b1, input int w2, input logic [7:0] b2,
                             input int dc, input logic [15:0] nd);
    int bm = 0, rm = 0;
    for (int k = 0; k < NB; k++) begin
      int m = 0;
      for (int j = 0; j < 16 * d; j++) begin
        int c = k * 16 * d + j;
        if (tx !== bits[k]) m++;
        if (busy !== 1'b1) bm++;
        if (ready !== ((w1 >= 0 && c > w1) ? 1'b0 : 1'b1)) rm++;
        write = (c == w1 || c == w2);
        char_i = (c == w1) ? b1 : b2;
        if (c == dc) div = nd;
        step;
      end
      total++;
      if (m != 0) begin
        bad++;
        $display("FAIL %s bit%0d tx wrong in %0d of %0d cycles, want %b", nm, k, m, 16 * d, bits[k]);
      end
    end
    write = 1'b0;
    total++;
    if (bm != 0) begin
      bad++;
      $display("FAIL %s busy low in %0d frame cycles, want 1", nm, bm);
    end
    total++;
    if (rm != 0) begin
      bad++;
      $display("FAIL %s ready wrong in %0d frame cycles", nm, rm);
    end
  endtask
  task automatic idle_check(input string nm, input int n);
    int m = 0;
    repeat (n) begin
      if ({tx, ready, busy} !== 3'b110) m++;
      step;
    end
    total++;
    if (m != 0) begin
      bad++;
      $display("FAIL %s idle {tx,ready,busy}!=110 in %0d of %0d cycles", nm, m, n);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    total++;
    if ({tx, ready, busy} !== 3'b110) begin
      bad++;
      $display("FAIL reset {tx,ready,busy}=%b want 110", {tx, ready, busy});
    end
    rst = 1'b0;
    idle_check("reset_idle", 100);
  endtask
  task automatic test_single;
    div = 16'd1;
    send_idle("single", 8'h41);
    check_frame("single", fr(8'h41, 1'b0), 1, -1, 8'h00, -1, 8'h00, -1, 16'd0);
    idle_check("single_end", 20);
  endtask
  task automatic test_back_to_back;
    div = 16'd3;
    send_idle("b2b", 8'h55);
    check_frame("b2b_f1", fr(8'h55, 1'b0), 3, 0, 8'hA3, 1, 8'hFF, -1, 16'd0);
    check_frame("b2b_f2", fr(8'hA3, 1'b0), 3, -1, 8'h00, -1, 8'h00, -1, 16'd0);
    idle_check("b2b_dropped", 100);
  endtask
  task automatic test_div_change;
    div = 16'd2;
    send_idle("divchg", 8'h3C);
    check_frame("divchg_f1", fr(8'h3C, 1'b0), 2, -1, 8'h00, -1, 8'h00, 3 * 32 + 5, 16'd5);
    idle_check("divchg_gap", 5);
    send_idle("divchg2", 8'h81);
    check_frame("divchg_f2", fr(8'h81, 1'b0), 5, -1, 8'h00, -1, 8'h00, -1, 16'd0);
    idle_check("divchg_end", 5);
  endtask
  task automatic test_reset_mid;
    int m = 0;
    div = 16'd1;
    send_idle("rstmid", 8'h5A);
    for (int c = 0; c < 83; c++) begin
      write = (c == 10);
      char_i = 8'h99;
      step;
    end
    write = 1'b0;
    total++;
    if ({tx, busy} !== 2'b11) begin
      bad++;
      $display("FAIL rstmid before reset {tx,busy}=%b want 11", {tx, busy});
    end
    rst = 1'b1;
    step;
    total++;
    if ({tx, ready, busy} !== 3'b110) begin
      bad++;
      $display("FAIL rstmid after reset {tx,ready,busy}=%b want 110", {tx, ready, busy});
    end
    rst = 1'b0;
    idle_check("rstmid_quiet", 200);
  endtask
  task automatic test_loopback;
    div = 16'd2;
    send_idle("loop", 8'h00);
    check_frame("loop_00", fr(8'h00, 1'b0), 2, 5, 8'hFF, -1, 8'h00, -1, 16'd0);
    check_frame("loop_ff", fr(8'hFF, 1'b0), 2, 5, 8'h41, -1, 8'h00, -1, 16'd0);
    check_frame("loop_41", fr(8'h41, 1'b0), 2, -1, 8'h00, -1, 8'h00, -1, 16'd0);
    idle_check("loop_end", 20);
  endtask
  task automatic test_parity;
    div = 16'd1;
    send_idle("par", 8'h07);
    check_frame("par_07", fr(8'h07, 1'b1), 1, 3, 8'h03, -1, 8'h00, -1, 16'd0);
    check_frame("par_03", fr(8'h03, 1'b0), 1, -1, 8'h00, -1, 8'h00, -1, 16'd0);
    idle_check("par_end", 20);
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_div_change;
    test_reset_mid;
    test_loopback;
    test_parity;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/transmitter.md
# transmitter

UART-style serial transmitter, the transmit end of the link served by `receiver`. It accepts bytes from the core through a one-entry holding register and serialises each one on `tx`. Frames are 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1). The bit rate is derived from `sclk` using the same 16-bit divisor input as `receiver`. Placed beside `receiver` on the same `sclk` domain; `tx` drives the off-chip line or a loopback to `receiver.rx`.

## Interface
- No parameters; frame format fixed except as noted in Configuration.
- `sclk` input 1: system clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `write` input 1: byte strobe; accepted only when `ready`=1 at the same edge.
- `ready` output 1: holding register empty, so a byte can be accepted.
- `char` input 8: byte to send, sampled with an accepted `write`.
- `div` input 16: baud divisor; one tick every `div` sclk cycles; 0 treated as 1.
- `tx` output 1: serial line, idle high.
- `busy` output 1: a frame is on the line (state ≠ IDLE).

## Operation
- Holding register `hold[7:0]` with a full flag. `ready` = ~full, registered.
- Accepted `write` sets full and latches `char`. A `write` while `ready`=0 is ignored; the byte is dropped and the holding register is unchanged.
- Shifter FSM states: IDLE, START, DATA, STOP, plus PARITY when enabled.
  - IDLE with full=1: load shifter from `hold`, clear full, latch `div` into `div_q`, go to START.
  - START → DATA → STOP, each bit lasting 16 ticks.
  - DATA walks bit index 0..7 (3-bit counter) and emits `shift[0]`, shifting right after each bit.
  - STOP end: if full=1, load the next byte and go directly to START (no idle gap). Otherwise go to IDLE.
- Tick generator:
  - 16-bit counter reloaded at frame start; pulses when it reaches `div_q`-1, then wraps to 0.
  - 4-bit tick counter per bit; bit ends on its 16th tick.
- Bit period = 16·max(`div_q`,1) sclk cycles. Frame = 10 bit periods (11 with parity).
- `div` is sampled only at frame load. Changes mid-frame take effect on the next frame.
- Outputs per state:
  - `tx`: 1 in IDLE and STOP, 0 in START, data bit in DATA.
  - `busy`=1 in all states except IDLE.

## Timing
- Reset values:
  - `tx`=1, `ready`=1, `busy`=0.
  - FSM=IDLE, full=0, all counters 0.
- `rst` mid-frame: next edge forces `tx`=1 and IDLE. The pending and in-flight bytes are discarded. No partial stop bit is generated.
- Write in cycle N (idle transmitter):
  - N+1: `ready`=0, full=1.
  - N+2: shifter loaded, `tx`=0, `busy`=1, `ready`=1.
  - Start bit lasts from edge N+2 for 16·div cycles.
- Write during a frame: `ready`=0 from N+1 until the edge that loads the shifter at the end of the current STOP bit.
- Simultaneous write and shifter load on the same edge: `ready` is already 0, so the write is ignored.
- `tx` and `busy` are registered; no combinational path from `write` to `tx`.

## Configuration
- `TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP.
  - It emits even parity (XOR of the 8 data bits), held 16 ticks.
  - Frame = 11 bit periods.
- Undefined: no PARITY state, 10-bit frame. No parity logic is synthesised.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, release → `tx`=1, `ready`=1, `busy`=0 for 100 cycles.
- Single byte, `div`=1: write 0x41 → `tx` = 0,1,0,0,0,0,0,1,0,1. Each bit lasts 16 cycles, start bit begins at N+2, `busy` falls after 160 cycles.
- Back-to-back, `div`=3:
  - Write 0x55, then 0xA3 once `ready` rises.
  - Required: two frames with no idle cycle between stop and start. `ready` stays low from the second write until the end of frame 1.
  - A third write while `ready`=0 is dropped.
- Divisor change mid-frame: `div`=2 at load, switch to 5 during DATA → current frame keeps 32-cycle bits, next frame uses 80-cycle bits.
- Reset mid-frame: assert `rst` during DATA bit 4 → `tx`=1 next edge, `busy`=0, `ready`=1, and no further transitions.
- Loopback with `receiver` (same `div`): send 0x00, 0xFF, 0x41 → `receiver` reports the same three bytes in order.
- With `TX_PARITY_EN`: 0x07 gives parity bit 1 and 0x03 gives parity bit 0, each frame 11 bits.
